// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR execute unit: instruction kinds,
// CSR addresses, trap cause codes and the execute-unit state encoding.
package csr_pkg;

    typedef enum logic [3:0] {
        sysk_invalid = 4'd0,
        sysk_ecall   = 4'd1,
        sysk_ebreak  = 4'd2,
        sysk_csrrw   = 4'd3,
        sysk_csrrs   = 4'd4,
        sysk_csrrc   = 4'd5,
        sysk_csrrwi  = 4'd6,
        sysk_csrrsi  = 4'd7,
        sysk_csrrci  = 4'd8
    } system_kind_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } csr_state_t;

    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;

    // True for the CSR forms that take their operand from the zimm field.
    function automatic logic is_imm_form(input system_kind_t k);
        return (k == sysk_csrrwi) || (k == sysk_csrrsi) || (k == sysk_csrrci);
    endfunction

    function automatic logic is_csr_form(input system_kind_t k);
        return (k == sysk_csrrw)  || (k == sysk_csrrs)  || (k == sysk_csrrc) ||
               (k == sysk_csrrwi) || (k == sysk_csrrsi) || (k == sysk_csrrci);
    endfunction

endpackage

// File: rtl/csr_exec_unit_cycle_counter.sv
// 64-bit free-running cycle counter with independent write ports for each
// half; also supplies the read data for the mcycle/cycle address aliases.
module csr_cycle_counter
    import csr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    input  logic [11:0] addr_i,
    output logic [31:0] rdata_o,
    output logic        hit_o
);

    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic [31:0] lo_d;
    logic [31:0] hi_d;
    logic        carry;

    // Next count: a written half takes the write data instead of incrementing,
    // and a written low half never carries into the high half.
    always_comb begin
        carry = (lo_q == 32'hFFFF_FFFF) && !wr_lo_i;
        lo_d  = wr_lo_i ? wdata_i : (lo_q + 32'd1);
        hi_d  = wr_hi_i ? wdata_i : (hi_q + {31'b0, carry});
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    // Read mux for the machine and user aliases of both halves.
    always_comb begin
        rdata_o = '0;
        hit_o   = 1'b1;
        case (addr_i)
            CSR_MCYCLE,  CSR_CYCLE:  rdata_o = lo_q;
            CSR_MCYCLEH, CSR_CYCLEH: rdata_o = hi_q;
            default:                 hit_o   = 1'b0;
        endcase
    end

endmodule

// File: rtl/csr_exec_unit.sv
// SYSTEM-instruction execute unit: owns the machine-mode CSR file, performs
// CSR read-modify-write, returns the old value and raises precise traps.
//
// state | meaning
// IDLE  | ready for a request; inputs latched on accept
// EXEC  | read old value, compute new value, commit write or trap state
// RESP  | response held stable until resp_ready_i
module csr_exec_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
    parameter logic [31:0] HART_ID     = 32'h0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  system_kind_t kind_i,
    input  logic [11:0]  csr_addr_i,
    input  logic [4:0]   rs1_field_i,
    input  logic [31:0]  rs1_data_i,
    input  logic [4:0]   rd_i,
    input  logic [31:0]  pc_i,
    output logic         resp_valid_o,
    input  logic         resp_ready_i,
    output logic         resp_rd_we_o,
    output logic [4:0]   resp_rd_o,
    output logic [31:0]  resp_rd_data_o,
    output logic         trap_valid_o,
    output logic [31:0]  trap_target_o
);

    csr_state_t   state_q;
    system_kind_t kind_q;
    logic [11:0]  addr_q;
    logic [4:0]   rs1f_q;
    logic [31:0]  rs1d_q;
    logic [4:0]   rd_q;
    logic [31:0]  pc_q;

    logic [31:0]  mscratch_q;
    logic [31:0]  mtvec_q;
    logic [31:0]  mepc_q;
    logic [31:0]  mcause_q;

    logic         req_ready_q;
    logic         resp_valid_q;
    logic         resp_rd_we_q;
    logic [4:0]   resp_rd_q;
    logic [31:0]  resp_rd_data_q;
    logic         trap_valid_q;
    logic [31:0]  trap_target_q;

    logic         is_csr;
    logic [31:0]  operand;
    logic         wr_req;
    logic [31:0]  old_val;
    logic         addr_hit;
    logic         illegal;
    logic         trap;
    logic [31:0]  cause;
    logic [31:0]  new_val;
    logic         csr_we;
    logic         trap_commit;
    logic [31:0]  cnt_rdata;
    logic         cnt_hit;
    logic         cnt_wr_lo;
    logic         cnt_wr_hi;

    assign req_ready_o    = req_ready_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_rd_we_o   = resp_rd_we_q;
    assign resp_rd_o      = resp_rd_q;
    assign resp_rd_data_o = resp_rd_data_q;
    assign trap_valid_o   = trap_valid_q;
    assign trap_target_o  = trap_target_q;

    // Decode of the latched instruction: operand, old value, legality, new value.
    always_comb begin
        is_csr  = is_csr_form(kind_q);
        operand = is_imm_form(kind_q) ? {27'b0, rs1f_q} : rs1d_q;
        // Set/clear forms with rs1 = x0 / zimm = 0 are pure reads.
        wr_req  = is_csr && ((kind_q == sysk_csrrw) || (kind_q == sysk_csrrwi) ||
                             (rs1f_q != 5'd0));

        old_val  = '0;
        addr_hit = 1'b1;
        case (addr_q)
            CSR_MSCRATCH: old_val = mscratch_q;
            CSR_MTVEC:    old_val = mtvec_q & 32'hFFFF_FFFC;
            CSR_MEPC:     old_val = mepc_q & 32'hFFFF_FFFE;
            CSR_MCAUSE:   old_val = mcause_q;
            CSR_MHARTID:  old_val = HART_ID;
            default: begin
                old_val  = cnt_rdata;
                addr_hit = cnt_hit;
            end
        endcase

        illegal = is_csr && (!addr_hit || (wr_req && (addr_q[11:10] == 2'b11)));
        trap    = !is_csr || illegal;

        case (kind_q)
            sysk_ecall:  cause = CAUSE_ECALL_M;
            sysk_ebreak: cause = CAUSE_BREAKPOINT;
            default:     cause = CAUSE_ILLEGAL;
        endcase

        case (kind_q)
            sysk_csrrw, sysk_csrrwi: new_val = operand;
            sysk_csrrs, sysk_csrrsi: new_val = old_val | operand;
            default:                 new_val = old_val & ~operand;
        endcase

        csr_we      = (state_q == EXEC) && wr_req && !illegal;
        trap_commit = (state_q == EXEC) && trap;
        cnt_wr_lo   = csr_we && (addr_q == CSR_MCYCLE);
        cnt_wr_hi   = csr_we && (addr_q == CSR_MCYCLEH);
    end

    csr_cycle_counter u_cycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_lo_i (cnt_wr_lo),
        .wr_hi_i (cnt_wr_hi),
        .wdata_i (new_val),
        .addr_i  (addr_q),
        .rdata_o (cnt_rdata),
        .hit_o   (cnt_hit)
    );

    // CSR file: trap state takes priority, otherwise the software write lands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mscratch_q <= '0;
            mtvec_q    <= RESET_MTVEC;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (trap_commit) begin
            mepc_q   <= pc_q;
            mcause_q <= cause;
        end else if (csr_we) begin
            case (addr_q)
                CSR_MSCRATCH: mscratch_q <= new_val;
                CSR_MTVEC:    mtvec_q    <= new_val;
                CSR_MEPC:     mepc_q     <= new_val;
                CSR_MCAUSE:   mcause_q   <= new_val;
                default:      ;
            endcase
        end
    end

    // Request/response sequencing with registered handshake and result outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            kind_q         <= sysk_invalid;
            addr_q         <= '0;
            rs1f_q         <= '0;
            rs1d_q         <= '0;
            rd_q           <= '0;
            pc_q           <= '0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_rd_we_q   <= 1'b0;
            resp_rd_q      <= '0;
            resp_rd_data_q <= '0;
            trap_valid_q   <= 1'b0;
            trap_target_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        kind_q      <= kind_i;
                        addr_q      <= csr_addr_i;
                        rs1f_q      <= rs1_field_i;
                        rs1d_q      <= rs1_data_i;
                        rd_q        <= rd_i;
                        pc_q        <= pc_i;
                        req_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    resp_valid_q   <= 1'b1;
                    resp_rd_q      <= rd_q;
                    resp_rd_data_q <= trap ? 32'h0 : old_val;
                    resp_rd_we_q   <= !trap && (rd_q != 5'd0);
                    trap_valid_q   <= trap;
                    // mtvec_q still holds the pre-write value here.
                    trap_target_q  <= mtvec_q & 32'hFFFF_FFFC;
                    state_q        <= RESP;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        resp_rd_we_q <= 1'b0;
                        trap_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule
